ysyx_23060072_ifu_prefetch: RTL and testbench
=============================================

# ysyx_23060072_ifu_prefetch

Instruction prefetch queue between the instruction-memory bus and the IF stage. Issues sequential word fetches ahead of demand, buffers in-order responses in a small FIFO, and presents them to IF with valid/ready. On a controller redirect it discards queued and in-flight instructions and restarts fetch at the new PC.

## Interface
- DEPTH, 4: FIFO entries, power of two, 2..16; also the maximum number of outstanding requests.
- RESET_PC, 32'h8000_0000: first fetch address after reset.

Ports:
- clk  in  1  core clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- flush_i  in  1  redirect from controller (clean_flag).
- jump_pc_i  in  32  redirect target, valid with flush_i.
- imem_req_valid_o  out  1  fetch request valid.
- imem_req_ready_i  in  1  bus accepts request.
- imem_req_addr_o  out  32  word-aligned fetch address.
- imem_rsp_valid_i  in  1  response valid; responses return in request order, always accepted.
- imem_rsp_data_i  in  32  instruction word.
- imem_rsp_err_i  in  1  bus error for this response.
- instr_valid_o  out  1  queue head valid.
- instr_ready_i  in  1  IF consumes head (low = IF hold).
- instr_pc_o  out  32  PC of head.
- instr_rdata_o  out  32  instruction of head.
- instr_err_o  out  1  head carries a bus error.

## Operation
- State: fetch_pc, FIFO (pc, data, err) with rd/wr pointers and count, outstanding counter (0..DEPTH), drop counter (0..DEPTH).
- Issue: imem_req_valid_o = !rst && (count + outstanding − drop_adjusted) < DEPTH; address = fetch_pc. On accept: fetch_pc += 4, outstanding += 1.
- Request stability: while valid && !ready, address holds unless flush_i. The bus permits withdrawal; a flush may change the address of an unaccepted request.
- Response: outstanding −= 1. If drop > 0: drop −= 1, response discarded. Otherwise the FIFO is written with pc = tag recorded at issue (pc FIFO pushed on accept), data, and err.
- Pop: instr_valid_o && instr_ready_i advances rd pointer.
- Flush (priority over everything): count ← 0, fetch_pc ← {jump_pc_i[31:2],2'b00}, drop ← outstanding after this cycle's accept/response (an accept in the flush cycle is counted and later dropped; a response in the flush cycle is discarded). A pop in the flush cycle is ignored.
- Never overflows: issue credit reserves a slot for every outstanding request.
- Error responses are queued like normal ones; no retry.
- Arithmetic: fetch_pc wraps modulo 2^32; counters are sized to hold DEPTH exactly.

## Timing
- During rst: all outputs 0 except imem_req_addr_o = RESET_PC; counters 0; fetch_pc = RESET_PC.
- First cycle after rst deasserts: imem_req_valid_o = 1, addr = RESET_PC.
- Issue throughput: 1 request/cycle while credit remains.
- Response at cycle N → instr_valid_o at N+1 (default build).
- Flush at cycle N → instr_valid_o = 0 at N+1; new request at jump_pc_i at N+1.
- Full queue with pop and response in the same cycle: both occur, count unchanged.
- Empty queue: instr_valid_o = 0; outputs hold their last values (don't-care).
- rst mid-operation clears all state; in-flight responses after rst are not dropped. The bus is reset with the core.

## Configuration
- YSYX_23060072_PREFETCH_BYPASS_EN defined: when the FIFO is empty, drop = 0, and imem_rsp_valid_i is high, the response drives instr_* combinationally in the same cycle. If instr_ready_i is also high, it is not written to the FIFO. Response at N → instr_valid_o at N.
- Undefined: all instr_* outputs come from FIFO registers only, adding one cycle of latency.

## Test plan
- Reset release, bus always ready, 1-cycle response → requests 0x80000000, 0x80000004, ... on consecutive cycles; instr_pc_o sequence matches; instr_valid_o first high 2 cycles after first accept (1 with bypass).
- instr_ready_i held low, DEPTH=4 → exactly 4 accepted requests, then imem_req_valid_o = 0; count = 4, no overwrite; releasing ready drains 4 in order, then issue resumes.
- imem_req_ready_i low for 3 cycles → addr stable at 0x80000000 across the stall, single accept.
- 3 requests outstanding, flush_i with jump_pc_i = 0x80000100 → the next 3 responses are discarded; first instr_pc_o after flush = 0x80000100.
- Flush in the same cycle as a response and a pop with a full queue → queue empty next cycle; the response is not visible; no underflow of count.
- Response with imem_rsp_err_i = 1 at PC 0x80000008 → instr_err_o = 1 only for that entry, fetch continues at 0x8000000C.

Source files
------------

// File: rtl/ysyx_23060072_ifu_prefetch.sv
// ysyx_23060072_ifu_prefetch: instruction prefetch queue between the
// instruction-memory bus and the IF stage.
//
// Issues sequential word fetches ahead of demand, buffers in-order
// responses in a DEPTH-entry FIFO and presents the head to IF with
// valid/ready. A flush discards queued and in-flight words and restarts
// fetch at the redirect target.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush_i, jump_pc_i  redirect request and target
//   imem_req_*          fetch request (valid/ready, word address)
//   imem_rsp_*          in-order response (valid, data, err)
//   instr_*             queue head to IF (valid/ready, pc, rdata, err)
//
// Build option: YSYX_23060072_PREFETCH_BYPASS_EN forwards a response
// straight to instr_* when the queue is empty (zero extra latency).
module ysyx_23060072_ifu_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [31:0] jump_pc_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    input  logic        imem_rsp_err_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_pc_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [31:0] r_fetch_pc;
    cnt_t        r_count;
    cnt_t        r_outst;
    cnt_t        r_drop;
    ptr_t        r_rd;
    ptr_t        r_wr;
    ptr_t        r_tag_rd;
    ptr_t        r_tag_wr;

    logic [31:0] r_pc_q   [DEPTH];
    logic [31:0] r_data_q [DEPTH];
    logic        r_err_q  [DEPTH];
    logic [31:0] r_tag_q  [DEPTH];

    logic [CW:0] w_live;
    logic        w_issue;
    logic        w_acc;
    logic        w_drop_rsp;
    logic        w_keep;
    logic        w_push;
    logic        w_pop;
    logic        w_fifo_vld;
    logic        w_out_vld;
    logic [31:0] w_rsp_pc;
    logic [31:0] w_jump;
    logic [31:0] w_head_pc;
    logic [31:0] w_head_data;
    logic        w_head_err;
    cnt_t        w_outst_nxt;

    // Live slots: queued words plus requests whose responses will be kept.
    // Outstanding is also capped so the issue-tag FIFO cannot overflow.
    assign w_live = {1'b0, r_count} + {1'b0, r_outst} - {1'b0, r_drop};
    assign w_issue = !rst && (w_live < (CW+1)'(DEPTH))
                          && (r_outst < CW'(DEPTH));
    assign w_acc = w_issue && imem_req_ready_i;

    assign w_drop_rsp = imem_rsp_valid_i && (r_drop != '0);
    assign w_keep     = imem_rsp_valid_i && (r_drop == '0) && !flush_i;
    assign w_rsp_pc   = r_tag_q[r_tag_rd];
    assign w_fifo_vld = (r_count != '0);
    assign w_jump     = jump_pc_i & 32'hFFFF_FFFC;

`ifdef YSYX_23060072_PREFETCH_BYPASS_EN
    logic w_byp;
    assign w_byp       = w_keep && !w_fifo_vld;
    assign w_out_vld   = w_fifo_vld || w_byp;
    assign w_push      = w_keep && !(w_byp && instr_ready_i);
    assign w_head_pc   = w_fifo_vld ? r_pc_q[r_rd]   : w_rsp_pc;
    assign w_head_data = w_fifo_vld ? r_data_q[r_rd] : imem_rsp_data_i;
    assign w_head_err  = w_fifo_vld ? r_err_q[r_rd]  : imem_rsp_err_i;
`else
    assign w_out_vld   = w_fifo_vld;
    assign w_push      = w_keep;
    assign w_head_pc   = r_pc_q[r_rd];
    assign w_head_data = r_data_q[r_rd];
    assign w_head_err  = r_err_q[r_rd];
`endif

    // A pop during a flush is ignored; the queue is emptied anyway.
    assign w_pop = w_fifo_vld && instr_ready_i && !flush_i;

    assign w_outst_nxt = r_outst + cnt_t'(w_acc) - cnt_t'(imem_rsp_valid_i);

    assign imem_req_valid_o = w_issue;
    assign imem_req_addr_o  = rst ? RESET_PC : r_fetch_pc;
    assign instr_valid_o    = !rst && w_out_vld;
    assign instr_pc_o       = rst ? '0 : w_head_pc;
    assign instr_rdata_o    = rst ? '0 : w_head_data;
    assign instr_err_o      = !rst && w_head_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_count    <= '0;
            r_outst    <= '0;
            r_drop     <= '0;
            r_rd       <= '0;
            r_wr       <= '0;
            r_tag_rd   <= '0;
            r_tag_wr   <= '0;
        end else begin
            // Tags track every bus transaction, dropped or not.
            r_outst  <= w_outst_nxt;
            r_tag_rd <= r_tag_rd + ptr_t'(imem_rsp_valid_i);
            r_tag_wr <= r_tag_wr + ptr_t'(w_acc);
            if (flush_i) begin
                r_fetch_pc <= w_jump;
                r_count    <= '0;
                r_rd       <= '0;
                r_wr       <= '0;
                r_drop     <= w_outst_nxt;
            end else begin
                if (w_acc) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_drop_rsp) begin
                    r_drop <= r_drop - cnt_t'(1);
                end
                r_count <= r_count + cnt_t'(w_push) - cnt_t'(w_pop);
                r_rd    <= r_rd + ptr_t'(w_pop);
                r_wr    <= r_wr + ptr_t'(w_push);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_tag_q[r_tag_wr] <= r_fetch_pc;
        end
        if (w_push) begin
            r_pc_q[r_wr]   <= w_rsp_pc;
            r_data_q[r_wr] <= imem_rsp_data_i;
            r_err_q[r_wr]  <= imem_rsp_err_i;
        end
    end

endmodule

// File: tb/tb_ysyx_23060072_ifu_prefetch.sv
// Testbench for ysyx_23060072_ifu_prefetch: bus model with 1-cycle
// responses and an in-order scoreboard of expected instructions.
module tb_ysyx_23060072_ifu_prefetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
`ifdef YSYX_23060072_PREFETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic [31:0] jump_pc_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        imem_rsp_err_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_pc_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;

    ysyx_23060072_ifu_prefetch #(
        .DEPTH    (4),
        .RESET_PC (RST_PC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .flush_i          (flush_i),
        .jump_pc_i        (jump_pc_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .imem_rsp_err_i   (imem_rsp_err_i),
        .instr_valid_o    (instr_valid_o),
        .instr_ready_i    (instr_ready_i),
        .instr_pc_o       (instr_pc_o),
        .instr_rdata_o    (instr_rdata_o),
        .instr_err_o      (instr_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] bus_q[$];

    int checks = 0;
    int errors = 0;

    logic        c_rst;
    logic        c_flush;
    logic [31:0] c_jump;
    logic        c_req_ready;
    logic        c_rsp_en;
    logic        c_instr_ready;
    logic [31:0] c_err_addr;

    logic        t_acc;
    logic [31:0] t_acc_addr;
    logic        t_pop;
    logic [31:0] t_pop_pc;
    logic        t_pop_err;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // One clock cycle: drive inputs at negedge, sample 1 time unit later.
    task automatic tick();
        exp_t        e;
        logic [31:0] a;
        @(negedge clk);
        rst              = c_rst;
        flush_i          = c_flush;
        jump_pc_i        = c_jump;
        imem_req_ready_i = c_req_ready;
        instr_ready_i    = c_instr_ready;
        if (c_rsp_en && !c_rst && bus_q.size() > 0) begin
            a = bus_q.pop_front();
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = mem_word(a);
            imem_rsp_err_i   = (a == c_err_addr);
        end else begin
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = '0;
            imem_rsp_err_i   = 1'b0;
        end
        #1;
        t_acc      = imem_req_valid_o && imem_req_ready_i;
        t_acc_addr = imem_req_addr_o;
        t_pop      = instr_valid_o && instr_ready_i && !flush_i;
        if (t_acc === 1'b1) begin
            bus_q.push_back(imem_req_addr_o);
            e.pc   = imem_req_addr_o;
            e.data = mem_word(imem_req_addr_o);
            e.err  = (imem_req_addr_o == c_err_addr);
            exp_q.push_back(e);
        end
        if (t_pop === 1'b1) begin
            t_pop_pc  = instr_pc_o;
            t_pop_err = instr_err_o;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_pop: got pc %h, expected no output",
                         instr_pc_o);
            end else begin
                e = exp_q.pop_front();
                if ({instr_pc_o, instr_rdata_o, instr_err_o}
                    !== {e.pc, e.data, e.err}) begin
                    errors++;
                    $display("FAIL sb_pop: got %h/%h/%b, expected %h/%h/%b",
                             instr_pc_o, instr_rdata_o, instr_err_o,
                             e.pc, e.data, e.err);
                end
            end
        end
        if (flush_i || rst) exp_q.delete();
        if (rst) bus_q.delete();
    endtask

    task automatic do_reset();
        c_rst = 1'b1;
        c_flush = 1'b0;
        c_jump = '0;
        c_req_ready = 1'b0;
        c_rsp_en = 1'b1;
        c_instr_ready = 1'b0;
        c_err_addr = 32'h1;
        tick();
        tick();
        c_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        c_rst = 1'b1;
        tick();
        checks++;
        if (imem_req_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_req_valid: got %b, expected 0", imem_req_valid_o);
        end
        checks++;
        if (imem_req_addr_o !== RST_PC) begin
            errors++;
            $display("FAIL rst_addr: got %h, expected %h", imem_req_addr_o, RST_PC);
        end
        checks++;
        if ({instr_valid_o, instr_pc_o, instr_rdata_o, instr_err_o} !== '0) begin
            errors++;
            $display("FAIL rst_instr: got %b/%h/%h/%b, expected all 0",
                     instr_valid_o, instr_pc_o, instr_rdata_o, instr_err_o);
        end
        c_rst = 1'b0;
        tick();
        checks++;
        if ({imem_req_valid_o, imem_req_addr_o} !== {1'b1, RST_PC}) begin
            errors++;
            $display("FAIL rst_release: got %b/%h, expected 1/%h",
                     imem_req_valid_o, imem_req_addr_o, RST_PC);
        end
    endtask

    task automatic test_stream();
        int          first_acc;
        int          first_vld;
        int          n_acc;
        int          n_pop;
        logic [31:0] exp_addr;
        do_reset();
        c_req_ready = 1'b1;
        c_instr_ready = 1'b1;
        first_acc = -1;
        first_vld = -1;
        n_acc = 0;
        n_pop = 0;
        exp_addr = RST_PC;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (t_acc === 1'b1) begin
                checks++;
                if (t_acc_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL stream_addr: got %h, expected %h",
                             t_acc_addr, exp_addr);
                end
                exp_addr = exp_addr + 32'd4;
                n_acc++;
                if (first_acc < 0) first_acc = i;
            end
            if (instr_valid_o === 1'b1 && first_vld < 0) first_vld = i;
            if (t_pop === 1'b1) n_pop++;
        end
        checks++;
        if (n_acc !== 12) begin
            errors++;
            $display("FAIL stream_rate: got %0d accepts, expected 12", n_acc);
        end
        checks++;
        if (first_vld - first_acc !== LAT) begin
            errors++;
            $display("FAIL stream_latency: got %0d, expected %0d",
                     first_vld - first_acc, LAT);
        end
        checks++;
        if (n_pop !== 12 - LAT) begin
            errors++;
            $display("FAIL stream_pops: got %0d, expected %0d", n_pop, 12 - LAT);
        end
    endtask

    task automatic test_backpressure();
        int n_acc;
        int n_pop;
        do_reset();
        c_req_ready = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (t_acc === 1'b1) n_acc++;
        end
        checks++;
        if (n_acc !== 4) begin
            errors++;
            $display("FAIL bp_accepts: got %0d, expected 4", n_acc);
        end
        checks++;
        if ({imem_req_valid_o, instr_valid_o, instr_pc_o} !== {2'b01, RST_PC}) begin
            errors++;
            $display("FAIL bp_full: got %b/%b/%h, expected 0/1/%h",
                     imem_req_valid_o, instr_valid_o, instr_pc_o, RST_PC);
        end
        c_instr_ready = 1'b1;
        n_pop = 0;
        n_acc = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (t_pop === 1'b1) n_pop++;
            if (t_acc === 1'b1) n_acc++;
        end
        checks++;
        if (n_pop !== 4) begin
            errors++;
            $display("FAIL bp_drain: got %0d pops, expected 4", n_pop);
        end
        checks++;
        if ((n_acc > 0) !== 1'b1) begin
            errors++;
            $display("FAIL bp_resume: got %0d accepts, expected >0", n_acc);
        end
    endtask

    task automatic test_req_stall();
        do_reset();
        c_instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({imem_req_valid_o, imem_req_addr_o} !== {1'b1, RST_PC}) begin
                errors++;
                $display("FAIL stall_addr: got %b/%h, expected 1/%h",
                         imem_req_valid_o, imem_req_addr_o, RST_PC);
            end
        end
        c_req_ready = 1'b1;
        tick();
        checks++;
        if ({t_acc, t_acc_addr} !== {1'b1, RST_PC}) begin
            errors++;
            $display("FAIL stall_accept: got %b/%h, expected 1/%h",
                     t_acc, t_acc_addr, RST_PC);
        end
        c_req_ready = 1'b0;
        tick();
        checks++;
        if (imem_req_addr_o !== RST_PC + 32'd4) begin
            errors++;
            $display("FAIL stall_next: got %h, expected %h",
                     imem_req_addr_o, RST_PC + 32'd4);
        end
        c_req_ready = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_flush_drop();
        int          n_acc;
        logic [31:0] first_pc;
        do_reset();
        c_req_ready = 1'b1;
        c_rsp_en = 1'b0;
        c_instr_ready = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (t_acc === 1'b1) n_acc++;
        end
        checks++;
        if (n_acc !== 3) begin
            errors++;
            $display("FAIL fd_outstanding: got %0d, expected 3", n_acc);
        end
        c_req_ready = 1'b0;
        c_flush = 1'b1;
        c_jump = 32'h8000_0100;
        tick();
        c_flush = 1'b0;
        c_req_ready = 1'b1;
        c_rsp_en = 1'b1;
        tick();
        checks++;
        if ({instr_valid_o, imem_req_valid_o, imem_req_addr_o}
            !== {2'b01, 32'h8000_0100}) begin
            errors++;
            $display("FAIL fd_after: got %b/%b/%h, expected 0/1/80000100",
                     instr_valid_o, imem_req_valid_o, imem_req_addr_o);
        end
        first_pc = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (t_pop === 1'b1 && first_pc == '0) first_pc = t_pop_pc;
        end
        checks++;
        if (first_pc !== 32'h8000_0100) begin
            errors++;
            $display("FAIL fd_first_pc: got %h, expected 80000100", first_pc);
        end
    endtask

    task automatic test_flush_full();
        logic [31:0] first_pc;
        do_reset();
        c_req_ready = 1'b1;
        c_rsp_en = 1'b0;
        repeat (4) tick();
        c_rsp_en = 1'b1;
        repeat (3) tick();
        c_flush = 1'b1;
        c_jump = 32'h8000_0200;
        c_instr_ready = 1'b1;
        tick();
        checks++;
        if ({instr_valid_o, imem_rsp_valid_i} !== 2'b11) begin
            errors++;
            $display("FAIL ff_setup: got valid %b rsp %b, expected 1/1",
                     instr_valid_o, imem_rsp_valid_i);
        end
        c_flush = 1'b0;
        tick();
        checks++;
        if ({instr_valid_o, imem_req_valid_o, imem_req_addr_o}
            !== {2'b01, 32'h8000_0200}) begin
            errors++;
            $display("FAIL ff_empty: got %b/%b/%h, expected 0/1/80000200",
                     instr_valid_o, imem_req_valid_o, imem_req_addr_o);
        end
        first_pc = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (t_pop === 1'b1 && first_pc == '0) first_pc = t_pop_pc;
        end
        checks++;
        if (first_pc !== 32'h8000_0200) begin
            errors++;
            $display("FAIL ff_first_pc: got %h, expected 80000200", first_pc);
        end
    endtask

    task automatic test_error();
        int          n_err;
        logic [31:0] err_pc;
        logic        saw_next;
        do_reset();
        c_err_addr = 32'h8000_0008;
        c_req_ready = 1'b1;
        c_instr_ready = 1'b1;
        n_err = 0;
        err_pc = '0;
        saw_next = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (t_pop === 1'b1 && t_pop_err === 1'b1) begin
                n_err++;
                err_pc = t_pop_pc;
            end
            if (t_pop === 1'b1 && t_pop_pc == 32'h8000_000C && t_pop_err === 1'b0)
                saw_next = 1'b1;
        end
        checks++;
        if ({n_err == 1, err_pc} !== {1'b1, 32'h8000_0008}) begin
            errors++;
            $display("FAIL err_entry: got %0d errs at %h, expected 1 at 80000008",
                     n_err, err_pc);
        end
        checks++;
        if (saw_next !== 1'b1) begin
            errors++;
            $display("FAIL err_continue: got %b, expected 1", saw_next);
        end
        c_err_addr = 32'h1;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_addr;
        do_reset();
        c_req_ready = 1'b1;
        c_instr_ready = 1'b1;
        c_flush = 1'b1;
        c_jump = 32'hFFFF_FFFB;
        tick();
        c_flush = 1'b0;
        exp_addr = 32'hFFFF_FFF8;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({t_acc, t_acc_addr} !== {1'b1, exp_addr}) begin
                errors++;
                $display("FAIL wrap_addr: got %b/%h, expected 1/%h",
                         t_acc, t_acc_addr, exp_addr);
            end
            exp_addr = exp_addr + 32'd4;
        end
        repeat (4) tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] first_pc;
        do_reset();
        c_req_ready = 1'b1;
        c_instr_ready = 1'b1;
        repeat (5) tick();
        c_rst = 1'b1;
        tick();
        checks++;
        if ({instr_valid_o, imem_req_valid_o} !== 2'b00) begin
            errors++;
            $display("FAIL rmid_outputs: got %b/%b, expected 0/0",
                     instr_valid_o, imem_req_valid_o);
        end
        c_rst = 1'b0;
        first_pc = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (t_pop === 1'b1 && first_pc == '0) first_pc = t_pop_pc;
        end
        checks++;
        if (first_pc !== RST_PC) begin
            errors++;
            $display("FAIL rmid_first_pc: got %h, expected %h", first_pc, RST_PC);
        end
    endtask

    initial begin
        rst = 1'b1;
        flush_i = 1'b0;
        jump_pc_i = '0;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i = '0;
        imem_rsp_err_i = 1'b0;
        instr_ready_i = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_req_stall();
        test_flush_drop();
        test_flush_full();
        test_error();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
